tipi_rpi_rx: RTL and testbench

TIPI_RPI_RX -- requirements
Module: tipi_rpi_rx

---
 rtl/tipi_rpi_rx_pkg.sv | 26 ++
 rtl/tipi_rpi_rx_if.sv | 34 +++
 rtl/tipi_rpi_rx_sync_edge.sv | 33 +++
 rtl/tipi_rpi_rx.sv | 239 +++++++++++++++++++++++
 tb/tb_tipi_rpi_rx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tipi_rpi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tipi_pkg
// Brief    : Shared constants and FSM state encoding for the TIPI RPi receiver.
//            ERR state exists only when TIPI_RX_FRAME_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package tipi_pkg;

    localparam int          REG_W        = 8;
    localparam logic [15:0] TIPI_RD_ADDR = 16'h5FFB;
    localparam logic [15:0] TIPI_RC_ADDR = 16'h5FF9;

    typedef logic [1:0] tipi_state_t;

    localparam logic [1:0] C_ST_IDLE    = 2'd0;
    localparam logic [1:0] C_ST_SHIFT_D = 2'd1;
    localparam logic [1:0] C_ST_SHIFT_C = 2'd2;
`ifdef TIPI_RX_FRAME_CHECK_EN
    localparam logic [1:0] C_ST_ERR     = 2'd3;
`endif

    localparam logic [3:0] C_FULL_CNT   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/tipi_rpi_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : tipi_rpi_rx_if
// Brief    : RPi serial link and TI bus signals of the TIPI receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface tipi_rpi_rx_if;
    import tipi_pkg::*;

    logic             rpi_dclk;
    logic             rpi_cclk;
    logic             rpi_sdata;
    logic             rpi_le;
    logic [0:15]      ti_a;
    logic             ti_memen;
    logic             ti_dbin;
    logic             cru_dsr_en;
    logic [0:REG_W-1] reg_d;
    logic             reg_oe_n;

    modport master (
        output rpi_dclk, rpi_cclk, rpi_sdata, rpi_le,
        output ti_a, ti_memen, ti_dbin, cru_dsr_en,
        input  reg_d, reg_oe_n
    );

    modport slave (
        input  rpi_dclk, rpi_cclk, rpi_sdata, rpi_le,
        input  ti_a, ti_memen, ti_dbin, cru_dsr_en,
        output reg_d, reg_oe_n
    );

endinterface
`default_nettype wire

// File: rtl/tipi_rpi_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Two-flop synchronizer followed by a one-clk rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/tipi_rpi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tipi_rpi_rx
// Brief    : Receives RD/RC bytes from the RPi serial link and presents them
//            on the TI bus. Define TIPI_RX_FRAME_CHECK_EN for frame checking.
// Revision : 1.0 - initial release
// ============================================================================
module tipi_rpi_rx
    import tipi_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,
    tipi_rpi_rx_if.slave     bus,
    output logic [REG_W-1:0] rd_q,
    output logic [REG_W-1:0] rc_q,
    output logic             frame_err
);

    logic [2:0] w_async;
    logic [2:0] w_rise;
    logic       w_dp;
    logic       w_cp;
    logic       w_lp;
    logic       r_sd_meta;
    logic       r_sd_sync;

    assign w_async = {bus.rpi_le, bus.rpi_cclk, bus.rpi_dclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge u_sync_edge (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_async (w_async[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_dp = w_rise[0];
    assign w_cp = w_rise[1];
    assign w_lp = w_rise[2];

    // Same depth as the clock synchronizers so data lines up with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sd_meta <= 1'b0;
            r_sd_sync <= 1'b0;
        end else begin
            r_sd_meta <= bus.rpi_sdata;
            r_sd_sync <= r_sd_meta;
        end
    end

    tipi_state_t      r_state;
    tipi_state_t      w_st_sh;
    tipi_state_t      w_state_n;
    logic [REG_W-1:0] r_shreg;
    logic [REG_W-1:0] w_shift_val;
    logic [REG_W-1:0] w_shreg_sh;
    logic [REG_W-1:0] w_shreg_n;
    logic [3:0]       r_bitcnt;
    logic [3:0]       w_cnt_sh;
    logic [3:0]       w_bitcnt_n;
    logic             w_commit_d;
    logic             w_commit_c;

    assign w_shift_val = {r_shreg[REG_W-2:0], r_sd_sync};

    // Shift stage: resolved first so a coincident latch sees the new count.
    always_comb begin
        w_st_sh    = r_state;
        w_shreg_sh = r_shreg;
        w_cnt_sh   = r_bitcnt;
`ifdef TIPI_RX_FRAME_CHECK_EN
        case (r_state)
            C_ST_IDLE: begin
                if (w_dp && w_cp) begin
                    w_st_sh = C_ST_ERR;
                end else if (w_dp) begin
                    w_st_sh    = C_ST_SHIFT_D;
                    w_shreg_sh = w_shift_val;
                    w_cnt_sh   = r_bitcnt + 4'd1;
                end else if (w_cp) begin
                    w_st_sh    = C_ST_SHIFT_C;
                    w_shreg_sh = w_shift_val;
                    w_cnt_sh   = r_bitcnt + 4'd1;
                end
            end
            C_ST_SHIFT_D: begin
                if (w_cp || (w_dp && r_bitcnt == C_FULL_CNT)) begin
                    w_st_sh = C_ST_ERR;
                end else if (w_dp) begin
                    w_shreg_sh = w_shift_val;
                    w_cnt_sh   = r_bitcnt + 4'd1;
                end
            end
            C_ST_SHIFT_C: begin
                if (w_dp || (w_cp && r_bitcnt == C_FULL_CNT)) begin
                    w_st_sh = C_ST_ERR;
                end else if (w_cp) begin
                    w_shreg_sh = w_shift_val;
                    w_cnt_sh   = r_bitcnt + 4'd1;
                end
            end
            default: ;
        endcase
`else
        // Unchecked mode: the most recent shift clock selects the target.
        if (w_dp || w_cp) begin
            w_st_sh    = w_dp ? C_ST_SHIFT_D : C_ST_SHIFT_C;
            w_shreg_sh = w_shift_val;
            w_cnt_sh   = (r_bitcnt == C_FULL_CNT) ? C_FULL_CNT : r_bitcnt + 4'd1;
        end
`endif
    end

`ifdef TIPI_RX_FRAME_CHECK_EN
    logic w_set_err;
    logic r_frame_err;
`endif

    // Latch stage: le in IDLE is ignored, anything else returns to IDLE.
    always_comb begin
        w_state_n  = w_st_sh;
        w_shreg_n  = w_shreg_sh;
        w_bitcnt_n = w_cnt_sh;
        w_commit_d = 1'b0;
        w_commit_c = 1'b0;
`ifdef TIPI_RX_FRAME_CHECK_EN
        w_set_err  = 1'b0;
`endif
        if (w_lp && w_st_sh != C_ST_IDLE) begin
`ifdef TIPI_RX_FRAME_CHECK_EN
            if (w_st_sh == C_ST_ERR || w_cnt_sh != C_FULL_CNT) begin
                w_set_err = 1'b1;
            end else begin
                w_commit_d = (w_st_sh == C_ST_SHIFT_D);
                w_commit_c = (w_st_sh == C_ST_SHIFT_C);
            end
`else
            w_commit_d = (w_st_sh == C_ST_SHIFT_D);
            w_commit_c = (w_st_sh == C_ST_SHIFT_C);
`endif
            w_state_n  = C_ST_IDLE;
            w_shreg_n  = '0;
            w_bitcnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= C_ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_n;
            r_shreg  <= w_shreg_n;
            r_bitcnt <= w_bitcnt_n;
        end
    end

`ifdef TIPI_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else if (w_commit_d || w_commit_c) begin
            r_frame_err <= 1'b0;
        end else if (w_set_err) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    logic w_rd_read;
    logic w_rc_read;

    assign w_rd_read = bus.cru_dsr_en && !bus.ti_memen && bus.ti_dbin &&
                       (bus.ti_a == TIPI_RD_ADDR);
    assign w_rc_read = bus.cru_dsr_en && !bus.ti_memen && bus.ti_dbin &&
                       (bus.ti_a == TIPI_RC_ADDR);

    logic [REG_W-1:0] r_rd_q;
    logic [REG_W-1:0] r_rd_pend;
    logic             r_rd_pend_v;
    logic [REG_W-1:0] r_rc_q;
    logic [REG_W-1:0] r_rc_pend;
    logic             r_rc_pend_v;

    // A register under read is never changed; the commit parks until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_q      <= '0;
            r_rd_pend   <= '0;
            r_rd_pend_v <= 1'b0;
        end else if (w_commit_d) begin
            if (w_rd_read) begin
                r_rd_pend   <= w_shreg_sh;
                r_rd_pend_v <= 1'b1;
            end else begin
                r_rd_q      <= w_shreg_sh;
                r_rd_pend_v <= 1'b0;
            end
        end else if (r_rd_pend_v && !w_rd_read) begin
            r_rd_q      <= r_rd_pend;
            r_rd_pend_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rc_q      <= '0;
            r_rc_pend   <= '0;
            r_rc_pend_v <= 1'b0;
        end else if (w_commit_c) begin
            if (w_rc_read) begin
                r_rc_pend   <= w_shreg_sh;
                r_rc_pend_v <= 1'b1;
            end else begin
                r_rc_q      <= w_shreg_sh;
                r_rc_pend_v <= 1'b0;
            end
        end else if (r_rc_pend_v && !w_rc_read) begin
            r_rc_q      <= r_rc_pend;
            r_rc_pend_v <= 1'b0;
        end
    end

    assign rd_q         = r_rd_q;
    assign rc_q         = r_rc_q;
    assign bus.reg_d    = w_rd_read ? r_rd_q : (w_rc_read ? r_rc_q : '0);
    assign bus.reg_oe_n = ~(w_rd_read | w_rc_read);

endmodule
`default_nettype wire

// File: tb/tb_tipi_rpi_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tipi_rpi_rx
// Brief    : Directed self-checking bench for tipi_rpi_rx (both build modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tipi_rpi_rx;

    logic       clk;
    logic       rst_n;
    logic [7:0] rd_q;
    logic [7:0] rc_q;
    logic       frame_err;
    int         n_tests;
    int         n_fail;
    logic [7:0] exp_rd;
    logic [7:0] exp_rc;
    logic       exp_fe;

    tipi_rpi_rx_if bus ();

    tipi_rpi_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rd_q      (rd_q),
        .rc_q      (rc_q),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       cru;
        logic       memen;
        logic       dbin;
        logic [15:0] addr;
        logic [7:0] exp_d;
        logic       exp_oe_n;
    } rd_vec_t;

    rd_vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic shift_bit(input logic is_c, input logic b);
        @(negedge clk);
        bus.rpi_sdata = b;
        if (is_c) bus.rpi_cclk = 1'b1;
        else      bus.rpi_dclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.rpi_dclk = 1'b0;
        bus.rpi_cclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic shift_byte(input logic is_c, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(is_c, v[i]);
    endtask

    task automatic pulse_le();
        @(negedge clk);
        bus.rpi_le = 1'b1;
        repeat (3) @(negedge clk);
        bus.rpi_le = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_rd_q"}, {24'd0, rd_q}, {24'd0, exp_rd});
        check({tag, "_rc_q"}, {24'd0, rc_q}, {24'd0, exp_rc});
        check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_fe});
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.rpi_dclk   = 1'b0;
        bus.rpi_cclk   = 1'b0;
        bus.rpi_sdata  = 1'b0;
        bus.rpi_le     = 1'b0;
        bus.ti_a       = 16'h0000;
        bus.ti_memen   = 1'b1;
        bus.ti_dbin    = 1'b0;
        bus.cru_dsr_en = 1'b0;
        exp_rd = 8'h00; exp_rc = 8'h00; exp_fe = 1'b0;

        #1;
        check_regs("reset");
        check("reset_oe_n", {31'd0, bus.reg_oe_n}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // RD byte with exact commit latency: third clk edge after le rises
        shift_byte(1'b0, 8'hA5);
        @(negedge clk);
        bus.rpi_le = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rd_before_3rd_edge", {24'd0, rd_q}, 32'h00);
        @(posedge clk); #1;
        check("rd_at_3rd_edge", {24'd0, rd_q}, 32'hA5);
        @(negedge clk);
        bus.rpi_le = 1'b0;
        repeat (3) @(negedge clk);
        exp_rd = 8'hA5;
        check_regs("rd_a5");

        shift_byte(1'b1, 8'h3C);
        pulse_le();
        exp_rc = 8'h3C;
        check_regs("rc_3c");

        // TI read decode table
        vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h5FF9, 8'h3C, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h5FFB, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h5FFB, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h5FFB, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h5FF9, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h5FFA, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h5FF8, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 16'hDFFB, 8'h00, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h5FFD, 8'h00, 1'b1};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.cru_dsr_en = vecs[i].cru;
            bus.ti_memen   = vecs[i].memen;
            bus.ti_dbin    = vecs[i].dbin;
            bus.ti_a       = vecs[i].addr;
            #1;
            check($sformatf("read_vec%0d_reg_d", i), {24'd0, bus.reg_d}, {24'd0, vecs[i].exp_d});
            check($sformatf("read_vec%0d_oe_n", i), {31'd0, bus.reg_oe_n}, {31'd0, vecs[i].exp_oe_n});
        end
        @(negedge clk);
        bus.cru_dsr_en = 1'b0; bus.ti_memen = 1'b1; bus.ti_dbin = 1'b0; bus.ti_a = 16'h0000;

        // Short frame: 5 bits 1,0,1,1,0
        shift_bit(1'b0, 1'b1); shift_bit(1'b0, 1'b0); shift_bit(1'b0, 1'b1);
        shift_bit(1'b0, 1'b1); shift_bit(1'b0, 1'b0);
        pulse_le();
`ifdef TIPI_RX_FRAME_CHECK_EN
        exp_fe = 1'b1;
`else
        exp_rd = 8'h16;
`endif
        check_regs("short_frame");

        shift_byte(1'b0, 8'h11);
        pulse_le();
        exp_rd = 8'h11; exp_fe = 1'b0;
        check_regs("good_after_short");

        // Mixed clocks: 3 dclk bits then 1 cclk bit
        shift_bit(1'b0, 1'b1); shift_bit(1'b0, 1'b1); shift_bit(1'b0, 1'b1);
        shift_bit(1'b1, 1'b1);
        pulse_le();
`ifdef TIPI_RX_FRAME_CHECK_EN
        exp_fe = 1'b1;
`else
        exp_rc = 8'h0F;
`endif
        check_regs("mixed_clocks");

        // Nine bits on dclk: 1 followed by 0x5A
        shift_bit(1'b0, 1'b1);
        shift_byte(1'b0, 8'h5A);
        pulse_le();
`ifdef TIPI_RX_FRAME_CHECK_EN
        exp_fe = 1'b1;
`else
        exp_rd = 8'h5A;
`endif
        check_regs("nine_bits");

        // RD commit while RD is being read
        @(negedge clk);
        bus.cru_dsr_en = 1'b1; bus.ti_memen = 1'b0; bus.ti_dbin = 1'b1; bus.ti_a = 16'h5FFB;
        shift_byte(1'b0, 8'h77);
        pulse_le();
        repeat (4) @(negedge clk);
        exp_fe = 1'b0;
        check_regs("held_during_read");
        check("held_reg_d", {24'd0, bus.reg_d}, {24'd0, exp_rd});
        @(negedge clk);
        bus.ti_dbin = 1'b0;
        #1;
        check("held_after_read_drop", {24'd0, rd_q}, {24'd0, exp_rd});
        @(posedge clk); #1;
        check("applied_after_read", {24'd0, rd_q}, 32'h77);
        exp_rd = 8'h77;

        // Two commits during one read: the later one wins
        @(negedge clk);
        bus.ti_dbin = 1'b1;
        shift_byte(1'b0, 8'h12);
        pulse_le();
        shift_byte(1'b0, 8'h34);
        pulse_le();
        check("pend_overwrite_held", {24'd0, rd_q}, 32'h77);
        @(negedge clk);
        bus.ti_dbin = 1'b0;
        @(posedge clk); #1;
        check("pend_overwrite_applied", {24'd0, rd_q}, 32'h34);
        exp_rd = 8'h34;

        // Reset mid-frame, then a stray le
        bus.cru_dsr_en = 1'b0; bus.ti_memen = 1'b1; bus.ti_a = 16'h0000;
        shift_bit(1'b0, 1'b1); shift_bit(1'b0, 1'b1);
        shift_bit(1'b0, 1'b0); shift_bit(1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_rd = 8'h00; exp_rc = 8'h00; exp_fe = 1'b0;
        check_regs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_le();
        repeat (3) @(negedge clk);
        check_regs("le_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
